midi_event_sched: RTL and testbench

MIDI_EVENT_SCHED -- requirements
Module: midi_event_sched

---
 rtl/midi_event_sched.sv | 176 +++++++++++++++++
 tb/tb_midi_event_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_event_sched.sv
// midi_event_sched
// Watches a 10-key keyboard and a program selector and turns every change
// into a MIDI message, one byte at a time, for a UART transmitter.
//
// Parameters:
//   CHANNEL    MIDI channel 0..15, OR-ed into every status byte
//   BASE_NOTE  note number of key bit 0 at zero pitch shift
//   VEL_ON     Note On velocity byte
//   VEL_OFF    Note Off velocity byte
//
// Ports:
//   clk          single clock, all state on its rising edge
//   rst          asynchronous, active-low reset
//   ena          MIDI output enable; low blocks new messages only
//   key[9:0]     current key state, bit i = key i held
//   pitchshift   unsigned shift, 12 = none, offset = pitchshift - 12
//   program_num  requested MIDI program (the word "program" is reserved
//                in SystemVerilog, hence the suffix)
//   tx_data      byte offered to the UART
//   tx_valid     tx_data is valid; held until tx_ready accepts it
//   tx_ready     UART can accept a byte
//   busy         high while a message is in progress
module midi_event_sched #(
    parameter int CHANNEL   = 0,
    parameter int BASE_NOTE = 60,
    parameter int VEL_ON    = 100,
    parameter int VEL_OFF   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [9:0] key,
    input  logic [4:0] pitchshift,
    input  logic [6:0] program_num,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    localparam logic [7:0] STATUS_PC  = 8'hC0 | 8'(CHANNEL);
    localparam logic [7:0] STATUS_ON  = 8'h90 | 8'(CHANNEL);
    localparam logic [7:0] STATUS_OFF = 8'h80 | 8'(CHANNEL);
    localparam logic [7:0] VEL_ON_B   = 8'(VEL_ON);
    localparam logic [7:0] VEL_OFF_B  = 8'(VEL_OFF);

    typedef enum logic [1:0] {IDLE, STAT, DAT1, DAT2} state_t;

    state_t     state;
    logic [9:0] sent;
    logic [6:0] prog_sent;
    logic [6:0] note_tab [10];

    // Message latched at selection time so that input changes during
    // transmission cannot disturb it.
    logic       lat_is_prog;
    logic [3:0] lat_idx;
    logic       lat_val;
    logic [6:0] lat_note;
    logic [6:0] lat_prog;
    logic [7:0] byte1;
    logic [7:0] byte2;

    logic [9:0] diff;
    logic       any_diff;
    logic [3:0] sel_idx;
    logic [8:0] note_sum;
    logic [6:0] note_new;

    // Lowest-index key whose state differs from what was last transmitted.
    always_comb begin
        diff     = key ^ sent;
        any_diff = |diff;
        sel_idx  = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (diff[i]) sel_idx = 4'(i);
        end
    end

    // Note number in 9-bit two's complement; bit 8 set means the sum went
    // negative (the largest positive sum is well below 256).
    always_comb begin
        note_sum = 9'(BASE_NOTE) + {5'b0, sel_idx} + {4'b0, pitchshift} - 9'd12;
        if (note_sum[8])
            note_new = 7'd0;
        else if (note_sum[7])
            note_new = 7'd127;
        else
            note_new = note_sum[6:0];
    end

    // Message sequencer. Outputs are registered; a byte moves on to the
    // next one only when the UART accepts it (tx_valid is high in every
    // non-IDLE state, so tx_ready alone marks a transfer there).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            sent        <= '0;
            prog_sent   <= '0;
            for (int i = 0; i < 10; i++) note_tab[i] <= '0;
            lat_is_prog <= 1'b0;
            lat_idx     <= '0;
            lat_val     <= 1'b0;
            lat_note    <= '0;
            lat_prog    <= '0;
            byte1       <= '0;
            byte2       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ena && ((program_num != prog_sent) || any_diff)) begin
                        state    <= STAT;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        if (program_num != prog_sent) begin
                            lat_is_prog <= 1'b1;
                            lat_prog    <= program_num;
                            tx_data     <= STATUS_PC;
                            byte1       <= {1'b0, program_num};
                            byte2       <= 8'h00;
                        end else begin
                            lat_is_prog <= 1'b0;
                            lat_idx     <= sel_idx;
                            lat_val     <= key[sel_idx];
                            lat_note    <= note_new;
                            if (key[sel_idx]) begin
                                tx_data <= STATUS_ON;
                                byte1   <= {1'b0, note_new};
                                byte2   <= VEL_ON_B;
                            end else begin
                                // Note Off repeats the note actually sounded,
                                // whatever the pitch shift is now.
                                tx_data <= STATUS_OFF;
                                byte1   <= {1'b0, note_tab[sel_idx]};
                                byte2   <= VEL_OFF_B;
                            end
                        end
                    end
                end
                STAT: begin
                    if (tx_ready) begin
                        tx_data <= byte1;
                        state   <= DAT1;
                    end
                end
                DAT1: begin
                    if (tx_ready) begin
                        if (lat_is_prog) begin
                            state     <= IDLE;
                            tx_valid  <= 1'b0;
                            busy      <= 1'b0;
                            prog_sent <= lat_prog;
                        end else begin
                            tx_data <= byte2;
                            state   <= DAT2;
                        end
                    end
                end
                DAT2: begin
                    if (tx_ready) begin
                        state         <= IDLE;
                        tx_valid      <= 1'b0;
                        busy          <= 1'b0;
                        sent[lat_idx] <= lat_val;
                        if (lat_val) note_tab[lat_idx] <= lat_note;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_event_sched.sv
// tb_midi_event_sched
// Drives three differently parameterised schedulers with shared key,
// program, pitch and enable stimulus (individual tx_ready per unit) and
// compares every cycle against a message-level reference model.
module tb_midi_event_sched;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [9:0] key;
    logic [4:0] pitchshift;
    logic [6:0] prog_num;
    logic       rdy [3];
    logic [7:0] txd [3];
    logic       txv [3];
    logic       bsy [3];

    int vectors;
    int errors;
    int cyc;

    midi_event_sched dut0 (
        .clk(clk), .rst(rst), .ena(ena), .key(key), .pitchshift(pitchshift),
        .program_num(prog_num), .tx_data(txd[0]), .tx_valid(txv[0]),
        .tx_ready(rdy[0]), .busy(bsy[0])
    );

    midi_event_sched #(.CHANNEL(9), .BASE_NOTE(120), .VEL_ON(127), .VEL_OFF(0)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .key(key), .pitchshift(pitchshift),
        .program_num(prog_num), .tx_data(txd[1]), .tx_valid(txv[1]),
        .tx_ready(rdy[1]), .busy(bsy[1])
    );

    midi_event_sched #(.CHANNEL(15), .BASE_NOTE(3), .VEL_ON(1), .VEL_OFF(99)) dut2 (
        .clk(clk), .rst(rst), .ena(ena), .key(key), .pitchshift(pitchshift),
        .program_num(prog_num), .tx_data(txd[2]), .tx_valid(txv[2]),
        .tx_ready(rdy[2]), .busy(bsy[2])
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ch_of(input int u);
        case (u)
            0: return 0;
            1: return 9;
            default: return 15;
        endcase
    endfunction

    function automatic int base_of(input int u);
        case (u)
            0: return 60;
            1: return 120;
            default: return 3;
        endcase
    endfunction

    function automatic int von_of(input int u);
        case (u)
            0: return 100;
            1: return 127;
            default: return 1;
        endcase
    endfunction

    function automatic int voff_of(input int u);
        case (u)
            0: return 64;
            1: return 0;
            default: return 99;
        endcase
    endfunction

    // Reference model: what has been transmitted so far, plus the message
    // currently on the wire as a list of bytes and a position in it.
    logic [9:0] m_sent [3];
    logic [6:0] m_prog [3];
    int         m_tab  [3][10];
    bit         m_busy [3];
    int         m_msg  [3][3];
    int         m_len  [3];
    int         m_pos  [3];
    bit         m_isprog [3];
    int         m_idx  [3];
    bit         m_val  [3];
    int         m_note [3];
    logic [6:0] m_plat [3];

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_sent[u] = '0;
            m_prog[u] = '0;
            m_busy[u] = 1'b0;
            m_pos[u]  = 0;
            m_len[u]  = 0;
            for (int i = 0; i < 10; i++) m_tab[u][i] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        for (int u = 0; u < 3; u++) begin
            if (m_busy[u]) begin
                if (rdy[u]) begin
                    m_pos[u]++;
                    if (m_pos[u] == m_len[u]) begin
                        m_busy[u] = 1'b0;
                        if (m_isprog[u]) begin
                            m_prog[u] = m_plat[u];
                        end else begin
                            m_sent[u][m_idx[u]] = m_val[u];
                            if (m_val[u]) m_tab[u][m_idx[u]] = m_note[u];
                        end
                    end
                end
            end else if (ena) begin
                if (prog_num != m_prog[u]) begin
                    m_busy[u]   = 1'b1;
                    m_isprog[u] = 1'b1;
                    m_plat[u]   = prog_num;
                    m_msg[u][0] = 'hC0 | ch_of(u);
                    m_msg[u][1] = int'(prog_num);
                    m_len[u]    = 2;
                    m_pos[u]    = 0;
                end else if (key != m_sent[u]) begin
                    int idx;
                    int n;
                    idx = 0;
                    for (int i = 9; i >= 0; i--) if (key[i] != m_sent[u][i]) idx = i;
                    n = base_of(u) + idx + int'(pitchshift) - 12;
                    if (n < 0) n = 0;
                    if (n > 127) n = 127;
                    m_busy[u]   = 1'b1;
                    m_isprog[u] = 1'b0;
                    m_idx[u]    = idx;
                    m_val[u]    = key[idx];
                    m_note[u]   = n;
                    m_len[u]    = 3;
                    m_pos[u]    = 0;
                    if (key[idx]) begin
                        m_msg[u][0] = 'h90 | ch_of(u);
                        m_msg[u][1] = n;
                        m_msg[u][2] = von_of(u);
                    end else begin
                        m_msg[u][0] = 'h80 | ch_of(u);
                        m_msg[u][1] = m_tab[u][idx];
                        m_msg[u][2] = voff_of(u);
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 3; u++) begin
            checkOutput($sformatf("u%0d tx_valid", u), int'(txv[u]), int'(m_busy[u]));
            checkOutput($sformatf("u%0d busy", u), int'(bsy[u]), int'(m_busy[u]));
            if (m_busy[u])
                checkOutput($sformatf("u%0d tx_data", u), int'(txd[u]), m_msg[u][m_pos[u]]);
        end
    endtask

    task automatic check_reset_outputs();
        for (int u = 0; u < 3; u++) begin
            checkOutput($sformatf("u%0d reset tx_valid", u), int'(txv[u]), 0);
            checkOutput($sformatf("u%0d reset busy", u), int'(bsy[u]), 0);
            checkOutput($sformatf("u%0d reset tx_data", u), int'(txd[u]), 0);
        end
    endtask

    // Inputs are always driven just after a falling edge.
    task automatic applyStimulus(input logic [9:0] k, input logic e, input logic [4:0] ps,
                                 input logic [6:0] p, input logic [2:0] rmask);
        key        = k;
        ena        = e;
        pitchshift = ps;
        prog_num   = p;
        for (int u = 0; u < 3; u++) rdy[u] = rmask[u];
    endtask

    // Advance one clock: model follows the rising edge, outputs are checked
    // on the falling edge.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            check_all();
        end
    endtask

    // Reset asserted half-way through a cycle: outputs must clear without
    // waiting for a clock edge.
    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
    endtask

    initial begin
        logic [9:0] k;
        logic       e;
        logic [4:0] ps;
        logic [6:0] p;
        logic [2:0] rm;

        vectors = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b0;
        applyStimulus(10'h000, 1'b0, 5'd12, 7'd0, 3'b111);
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Single key on then off, default parameters give 90 3E 64 / 80 3E 40.
        applyStimulus(10'h004, 1'b1, 5'd12, 7'd0, 3'b111);
        run_cycles(6);
        applyStimulus(10'h000, 1'b1, 5'd12, 7'd0, 3'b111);
        run_cycles(6);

        // Program change takes priority over a simultaneous key.
        applyStimulus(10'h001, 1'b1, 5'd12, 7'd7, 3'b111);
        run_cycles(10);
        applyStimulus(10'h000, 1'b1, 5'd12, 7'd7, 3'b111);
        run_cycles(6);

        // Two keys at once go out lowest index first.
        applyStimulus(10'h00A, 1'b1, 5'd12, 7'd7, 3'b111);
        run_cycles(10);

        // Note Off after a pitch-shift change uses the note that was sent.
        applyStimulus(10'h00B, 1'b1, 5'd12, 7'd7, 3'b111);
        run_cycles(6);
        applyStimulus(10'h00B, 1'b1, 5'd14, 7'd7, 3'b111);
        run_cycles(2);
        applyStimulus(10'h00A, 1'b1, 5'd14, 7'd7, 3'b111);
        run_cycles(6);

        // Clamping: top key at maximum shift, bottom key at minimum shift.
        applyStimulus(10'h20A, 1'b1, 5'd31, 7'd7, 3'b111);
        run_cycles(6);
        applyStimulus(10'h20B, 1'b1, 5'd0, 7'd7, 3'b111);
        run_cycles(6);

        // Back-pressure for several cycles in the middle of a message.
        applyStimulus(10'h20F, 1'b1, 5'd12, 7'd7, 3'b111);
        run_cycles(2);
        applyStimulus(10'h20F, 1'b1, 5'd12, 7'd7, 3'b000);
        run_cycles(5);
        applyStimulus(10'h20F, 1'b1, 5'd12, 7'd7, 3'b111);
        run_cycles(6);

        // Enable low holds back a pending key until re-enabled.
        applyStimulus(10'h21F, 1'b0, 5'd12, 7'd7, 3'b111);
        run_cycles(20);
        applyStimulus(10'h21F, 1'b1, 5'd12, 7'd7, 3'b111);
        run_cycles(6);

        // Reset in the middle of a message, then everything is re-sent.
        applyStimulus(10'h21F, 1'b1, 5'd12, 7'd0, 3'b111);
        run_cycles(2);
        pulse_reset();
        run_cycles(40);

        // Randomised traffic with occasional resets.
        k  = key;
        e  = 1'b1;
        ps = 5'd12;
        p  = 7'd0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 7) == 0) k[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) p = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) ps = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 29) == 0) e = ~e;
            for (int u = 0; u < 3; u++) rm[u] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            applyStimulus(k, e, ps, p, rm);
            run_cycles(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
